// File: rtl/sdram_init_pkg.sv
// Shared types and command encodings for the SDRAM power-up initialisation sequencer.
package sdram_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        PRE,
        TRP_W,
        AREF,
        TRFC_W,
        MRS,
        TMRD_W,
        DONE
    } init_state_e;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_AREF    = 4'b0001;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    localparam int A10_PRE_ALL = 10;

endpackage

// File: rtl/sdram_init_dly_cnt.sv
// Loadable down counter shared by every wait state of the init sequencer.
module sdram_init_dly_cnt #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the counter parks at zero until reloaded
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init sequencer: NOP wait, PRECHARGE-ALL, NUM_AREF refreshes, optional MRS.
// Define SDRAM_INIT_MRS_EN to include the LOAD MODE REGISTER step.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int               PWR_UP_CYC = 10000,
    parameter int               TRP_CYC    = 2,
    parameter int               TRFC_CYC   = 7,
    parameter int               TMRD_CYC   = 2,
    parameter int               NUM_AREF   = 2,
    parameter int               ADDR_W     = 13,
    parameter int               BA_W       = 2,
    parameter logic [ADDR_W-1:0] MODE_REG  = 'h033
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              sdram_en,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              init_busy,
    output logic              init_done
);

    localparam int CNT_W = $clog2(PWR_UP_CYC + 1);

    localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(PWR_UP_CYC - 1);
    localparam logic [CNT_W-1:0] TRP_LD  = (TRP_CYC  > 0) ? CNT_W'(TRP_CYC - 1)  : '0;
    localparam logic [CNT_W-1:0] TRFC_LD = (TRFC_CYC > 0) ? CNT_W'(TRFC_CYC - 1) : '0;

`ifdef SDRAM_INIT_MRS_EN
    localparam logic [CNT_W-1:0] TMRD_LD    = (TMRD_CYC > 0) ? CNT_W'(TMRD_CYC - 1) : '0;
    localparam init_state_e      AFTER_AREF = MRS;
`else
    localparam init_state_e      AFTER_AREF = DONE;
    logic [ADDR_W:0] unused_mrs_params;
    assign unused_mrs_params = {MODE_REG, TMRD_CYC[0]};
`endif

    generate
        if (PWR_UP_CYC < 1) begin : g_bad_pwr
            $error("sdram_init_seq: PWR_UP_CYC must be at least 1");
        end
        if (NUM_AREF < 1 || NUM_AREF > 15) begin : g_bad_aref
            $error("sdram_init_seq: NUM_AREF must be in 1..15");
        end
        if (ADDR_W < 11) begin : g_bad_addr
            $error("sdram_init_seq: ADDR_W must be at least 11");
        end
    endgenerate

    init_state_e       state, state_nx;
    logic              en_q;
    logic [3:0]        aref_cnt;
    logic              abort;
    logic              cnt_zero, cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic [3:0]        cmd_q, cmd_nx;
    logic [BA_W-1:0]   ba_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              busy_nx, done_nx;
    init_state_e       aref_next;

    assign abort     = (state != IDLE) && !sdram_en;
    assign aref_next = (aref_cnt < 4'(NUM_AREF)) ? AREF : AFTER_AREF;

    // Next-state selection; abort overrides normal advancement
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (sdram_en && !en_q) state_nx = PWRUP;
            PWRUP:  if (cnt_zero) state_nx = PRE;
            PRE:    state_nx = (TRP_CYC == 0) ? AREF : TRP_W;
            TRP_W:  if (cnt_zero) state_nx = AREF;
            AREF:   state_nx = (TRFC_CYC == 0) ? aref_next : TRFC_W;
            TRFC_W: if (cnt_zero) state_nx = aref_next;
`ifdef SDRAM_INIT_MRS_EN
            MRS:    state_nx = (TMRD_CYC == 0) ? DONE : TMRD_W;
            TMRD_W: if (cnt_zero) state_nx = DONE;
`endif
            DONE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        cmd_nx    = CMD_NOP;
        ba_nx     = '0;
        addr_nx   = '0;
        busy_nx   = 1'b1;
        done_nx   = 1'b0;
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state_nx)
            IDLE: begin
                cmd_nx  = CMD_INHIBIT;
                busy_nx = 1'b0;
            end
            PWRUP: begin
                cnt_load  = (state != PWRUP);
                cnt_value = PWR_LD;
            end
            PRE: begin
                cmd_nx               = CMD_PRE;
                addr_nx[A10_PRE_ALL] = 1'b1;
            end
            TRP_W: begin
                cnt_load  = (state != TRP_W);
                cnt_value = TRP_LD;
            end
            AREF: cmd_nx = CMD_AREF;
            TRFC_W: begin
                cnt_load  = (state != TRFC_W);
                cnt_value = TRFC_LD;
            end
`ifdef SDRAM_INIT_MRS_EN
            MRS: begin
                cmd_nx  = CMD_MRS;
                addr_nx = MODE_REG;
            end
            TMRD_W: begin
                cnt_load  = (state != TMRD_W);
                cnt_value = TMRD_LD;
            end
`endif
            DONE: begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
            default: begin
                cmd_nx  = CMD_INHIBIT;
                busy_nx = 1'b0;
            end
        endcase
    end

    // en_q keeps following the pin through reset, so a reset with sdram_en
    // already high is not mistaken for a fresh rising edge
    always_ff @(posedge sdram_clk) begin
        en_q <= sdram_en;
        if (sdram_rst) begin
            state      <= IDLE;
            cmd_q      <= CMD_INHIBIT;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
            aref_cnt   <= '0;
        end else begin
            state      <= state_nx;
            cmd_q      <= cmd_nx;
            sdram_ba   <= ba_nx;
            sdram_addr <= addr_nx;
            init_busy  <= busy_nx;
            init_done  <= done_nx;
            if (state_nx == IDLE || state_nx == PWRUP) begin
                aref_cnt <= '0;
            end else if (state_nx == AREF) begin
                aref_cnt <= aref_cnt + 4'd1;
            end
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;

    sdram_init_dly_cnt #(
        .W (CNT_W)
    ) u_dly_cnt (
        .clock (sdram_clk),
        .reset (sdram_rst),
        .clear (abort),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

endmodule
